// File: rtl/leaf_bridge_pkg.sv
// rtl/leaf_bridge_pkg.sv - shared state type and default constants for leaf_user_bridge
package leaf_bridge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_PAYLOAD_BITS = 32;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int STAT_BITS        = 32;

endpackage

// File: rtl/bridge_fifo.sv
// rtl/bridge_fifo.sv - per-channel FIFO with push/pop handshake and full/empty flags
module bridge_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head word is forced to zero when empty so nothing stale is ever presented.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/leaf_user_bridge.sv
// rtl/leaf_user_bridge.sv - start-gated FIFO bridge between interface and kernel; stats via LEAF_BRIDGE_STATS_EN
module leaf_user_bridge
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 1,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   ap_start,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]   if_dout,
    input  logic [NUM_IN_PORTS-1:0]                if_vld,
    output logic [NUM_IN_PORTS-1:0]                if_ack,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]   usr_din,
    output logic [NUM_IN_PORTS-1:0]                usr_vld,
    input  logic [NUM_IN_PORTS-1:0]                usr_ack,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  usr_dout,
    input  logic [NUM_OUT_PORTS-1:0]               usr_out_vld,
    output logic [NUM_OUT_PORTS-1:0]               usr_out_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  if_din,
    output logic [NUM_OUT_PORTS-1:0]               if_out_vld,
    input  logic [NUM_OUT_PORTS-1:0]               if_out_ack,
    output logic                                   running
`ifdef LEAF_BRIDGE_STATS_EN
    ,
    output logic [NUM_IN_PORTS*STAT_BITS-1:0]      stat_in_cnt,
    output logic [NUM_OUT_PORTS*STAT_BITS-1:0]     stat_out_cnt
`endif
);

    state_t state;
    state_t state_nxt;
    logic   ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE && ap_start) begin
            state_nxt = RUN;
        end
    end

    assign running = (state == RUN);

    // Keeps every ack low while reset is held; acks open on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        logic full;
        logic empty;

        assign if_ack[i]  = ready_q & ~full;
        assign usr_vld[i] = running & ~empty;

        bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (if_vld[i] & if_ack[i]),
            .push_data (if_dout[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .pop       (usr_vld[i] & usr_ack[i]),
            .pop_data  (usr_din[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .full      (full),
            .empty     (empty)
        );

`ifdef LEAF_BRIDGE_STATS_EN
        logic [STAT_BITS-1:0] cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if (usr_vld[i] & usr_ack[i]) begin
                cnt <= cnt + STAT_BITS'(1);
            end
        end
        assign stat_in_cnt[i*STAT_BITS +: STAT_BITS] = cnt;
`endif
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
        logic full;
        logic empty;

        assign usr_out_ack[j] = ready_q & running & ~full;
        assign if_out_vld[j]  = running & ~empty;

        bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (usr_out_vld[j] & usr_out_ack[j]),
            .push_data (usr_dout[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .pop       (if_out_vld[j] & if_out_ack[j]),
            .pop_data  (if_din[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .full      (full),
            .empty     (empty)
        );

`ifdef LEAF_BRIDGE_STATS_EN
        logic [STAT_BITS-1:0] cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if (if_out_vld[j] & if_out_ack[j]) begin
                cnt <= cnt + STAT_BITS'(1);
            end
        end
        assign stat_out_cnt[j*STAT_BITS +: STAT_BITS] = cnt;
`endif
    end

endmodule

// File: tb/tb_leaf_user_bridge.sv
// tb/tb_leaf_user_bridge.sv - directed self-checking bench for leaf_user_bridge
module tb_leaf_user_bridge;

    localparam int PB = 32;
    localparam int NI = 2;
    localparam int NO = 1;

    logic              clk;
    logic              reset;
    logic              ap_start;
    logic [NI*PB-1:0]  if_dout;
    logic [NI-1:0]     if_vld;
    logic [NI-1:0]     if_ack;
    logic [NI*PB-1:0]  usr_din;
    logic [NI-1:0]     usr_vld;
    logic [NI-1:0]     usr_ack;
    logic [NO*PB-1:0]  usr_dout;
    logic [NO-1:0]     usr_out_vld;
    logic [NO-1:0]     usr_out_ack;
    logic [NO*PB-1:0]  if_din;
    logic [NO-1:0]     if_out_vld;
    logic [NO-1:0]     if_out_ack;
    logic              running;
`ifdef LEAF_BRIDGE_STATS_EN
    logic [NI*32-1:0]  stat_in_cnt;
    logic [NO*32-1:0]  stat_out_cnt;
`endif

    int checks = 0;
    int errors = 0;

    leaf_user_bridge #(
        .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ap_start    (ap_start),
        .if_dout     (if_dout),
        .if_vld      (if_vld),
        .if_ack      (if_ack),
        .usr_din     (usr_din),
        .usr_vld     (usr_vld),
        .usr_ack     (usr_ack),
        .usr_dout    (usr_dout),
        .usr_out_vld (usr_out_vld),
        .usr_out_ack (usr_out_ack),
        .if_din      (if_din),
        .if_out_vld  (if_out_vld),
        .if_out_ack  (if_out_ack),
        .running     (running)
`ifdef LEAF_BRIDGE_STATS_EN
        ,
        .stat_in_cnt (stat_in_cnt),
        .stat_out_cnt(stat_out_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        ap_start    = 1'b0;
        if_dout     = '0;
        if_vld      = '0;
        usr_ack     = '0;
        usr_dout    = '0;
        usr_out_vld = '0;
        if_out_ack  = '0;

        #1;
        check("rst_if_ack", 64'(if_ack), 64'h0);
        check("rst_usr_vld", 64'(usr_vld), 64'h0);
        check("rst_out_ack", 64'(usr_out_ack), 64'h0);
        check("rst_if_out_vld", 64'(if_out_vld), 64'h0);
        check("rst_running", 64'(running), 64'h0);
        check("rst_usr_din", usr_din, 64'h0);
        #1 reset = 1'b0;
        tick();
        check("post_rst_ack", 64'(if_ack), 64'h3);
        check("idle_out_ack", 64'(usr_out_ack), 64'h0);

        // Accept while idle, present only after start
        if_dout[31:0] = 32'hA5A5A5A5;
        if_vld        = 2'b01;
        check("idle_push_ack", 64'(if_ack[0]), 64'h1);
        check("idle_usr_vld0", 64'(usr_vld[0]), 64'h0);
        tick();
        if_vld = '0;
        check("idle_hold_vld", 64'(usr_vld[0]), 64'h0);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check("start_running", 64'(running), 64'h1);
        check("start_usr_vld0", 64'(usr_vld[0]), 64'h1);
        check("start_usr_din0", 64'(usr_din[31:0]), 64'hA5A5A5A5);
        usr_ack[0] = 1'b1;
        tick();
        usr_ack[0] = 1'b0;
        check("drained_vld0", 64'(usr_vld[0]), 64'h0);

        // Fill port 2 past depth; fifth word is refused
        for (int k = 1; k <= 5; k++) begin
            if_dout[63:32] = 32'(k);
            if_vld[1]      = 1'b1;
            check($sformatf("fill_ack_w%0d", k), 64'(if_ack[1]), (k <= 4) ? 64'h1 : 64'h0);
            tick();
        end
        check("full_ack_stays0", 64'(if_ack[1]), 64'h0);
        check("full_head", 64'(usr_din[63:32]), 64'h1);
        check("no_block_port1", 64'(if_ack[0]), 64'h1);
        // Full with vld and ack together: pop only
        usr_ack[1] = 1'b1;
        tick();
        check("after_pop_ack", 64'(if_ack[1]), 64'h1);
        check("order_w2", 64'(usr_din[63:32]), 64'h2);
        tick();
        if_vld[1] = 1'b0;
        check("order_w3", 64'(usr_din[63:32]), 64'h3);
        tick();
        check("order_w4", 64'(usr_din[63:32]), 64'h4);
        tick();
        check("order_w5", 64'(usr_din[63:32]), 64'h5);
        check("w5_vld", 64'(usr_vld[1]), 64'h1);
        tick();
        check("port2_empty", 64'(usr_vld[1]), 64'h0);
        usr_ack[1] = 1'b0;

        // Output channel streaming, both sides always ready
        if_out_ack = 1'b1;
        for (int i = 0; i <= 17; i++) begin
            usr_out_vld = (i < 16) ? 1'b1 : 1'b0;
            usr_dout    = 32'(100 + i);
            if (i < 16) check($sformatf("stream_ack%0d", i), 64'(usr_out_ack), 64'h1);
            check($sformatf("stream_vld%0d", i), 64'(if_out_vld), (i >= 1 && i <= 16) ? 64'h1 : 64'h0);
            if (i >= 1 && i <= 16) check($sformatf("stream_dat%0d", i), 64'(if_din), 64'(100 + i - 1));
            tick();
        end
        usr_out_vld = '0;
        if_out_ack  = '0;

        // Mid-stream reset with 3 words buffered
        if_vld[0] = 1'b1;
        for (int k = 7; k <= 9; k++) begin
            if_dout[31:0] = 32'(k);
            tick();
        end
        if_vld[0] = 1'b0;
        check("pre_rst_vld", 64'(usr_vld[0]), 64'h1);
        reset = 1'b1;
        #1;
        check("midrst_usr_vld", 64'(usr_vld), 64'h0);
        check("midrst_if_ack", 64'(if_ack), 64'h0);
        check("midrst_din", usr_din, 64'h0);
        check("midrst_running", 64'(running), 64'h0);
        tick();
        reset = 1'b0;
        tick();
        check("rel_running", 64'(running), 64'h0);
        check("rel_if_ack", 64'(if_ack), 64'h3);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check("no_stale_vld", 64'(usr_vld), 64'h0);
        check("no_stale_out", 64'(if_out_vld), 64'h0);

`ifdef LEAF_BRIDGE_STATS_EN
        for (int k = 0; k < 10; k++) begin
            if_vld[0] = 1'b1;
            tick();
            if_vld[0]  = 1'b0;
            usr_ack[0] = 1'b1;
            tick();
            usr_ack[0] = 1'b0;
        end
        for (int k = 0; k < 7; k++) begin
            usr_out_vld = 1'b1;
            tick();
            usr_out_vld = 1'b0;
            if_out_ack  = 1'b1;
            tick();
            if_out_ack  = 1'b0;
        end
        check("stat_in", 64'(stat_in_cnt[31:0]), 64'd10);
        check("stat_out", 64'(stat_out_cnt[31:0]), 64'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
